// File: rtl/uart_fb_loader_pkg.sv
// Shared constants for the UART framebuffer loader: opcodes, framebuffer
// geometry and the loader's state encoding.
package uart_fb_loader_pkg;

  localparam int FB_DEPTH = 4800;
  localparam int FB_AW    = 13;

  localparam logic [FB_AW-1:0] FB_LAST = FB_AW'(FB_DEPTH - 1);
  localparam logic [FB_AW-1:0] FB_END  = FB_AW'(FB_DEPTH);

  localparam logic [7:0] OP_PIXEL = 8'h01;
  localparam logic [7:0] OP_FILL  = 8'h02;
  localparam logic [7:0] OP_FRAME = 8'h03;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_PIX_X      = 3'd1;
  localparam state_t ST_PIX_Y      = 3'd2;
  localparam state_t ST_PIX_C      = 3'd3;
  localparam state_t ST_FILL_C     = 3'd4;
  localparam state_t ST_FILLING    = 3'd5;
  localparam state_t ST_FRAME_DATA = 3'd6;

endpackage

// File: rtl/fb_xy_to_addr.sv
// Combinational pixel coordinate to linear framebuffer address mapping,
// plus a bounds check against the visible area.
module fb_xy_to_addr
  import uart_fb_loader_pkg::*;
#(
  parameter int H_PIX = 80,
  parameter int V_PIX = 60
) (
  input  logic [6:0]       x,
  input  logic [5:0]       y,
  output logic [FB_AW-1:0] addr,
  output logic             in_range
);

  // y*80 built from two shifts so no multiplier is needed.
  assign addr = ({7'd0, y} << 6) + ({7'd0, y} << 4) + {6'd0, x};

  assign in_range = ({25'd0, x} < H_PIX) && ({26'd0, y} < V_PIX);

endmodule

// File: rtl/uart_fb_loader_80x60.sv
// Byte-stream command decoder driving the 80x60 framebuffer write port.
// Define UART_FB_LOADER_TIMEOUT_EN to abort stalled partial commands.
module uart_fb_loader_80x60
  import uart_fb_loader_pkg::*;
#(
  parameter int H_PIX = 80,
  parameter int V_PIX = 60
`ifdef UART_FB_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 5000000
`endif
) (
  input  logic             CLK_50MHz,
  input  logic             RESET,
  input  logic [7:0]       RX_DATA,
  input  logic             RX_VALID,
  output logic             RX_READY,
  output logic             WE,
  output logic [FB_AW-1:0] WA,
  output logic [7:0]       WD,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
);

  state_t           state;
  logic [7:0]       x_reg;
  logic [7:0]       y_reg;
  logic [FB_AW-1:0] cnt;
  logic [FB_AW-1:0] pix_addr;
  logic             pix_in_range;
  logic             pix_ok;
  logic             accept;
  logic             timeout_hit;

  fb_xy_to_addr #(
    .H_PIX(H_PIX),
    .V_PIX(V_PIX)
  ) u_xy (
    .x        (x_reg[6:0]),
    .y        (y_reg[5:0]),
    .addr     (pix_addr),
    .in_range (pix_in_range)
  );

  // The sub-module sees truncated coordinates; the dropped high bits must be zero.
  assign pix_ok = pix_in_range && !x_reg[7] && (y_reg[7:6] == 2'b00);

  assign RX_READY = (state != ST_FILLING);
  assign BUSY     = (state != ST_IDLE);
  assign accept   = RX_VALID && RX_READY;

`ifdef UART_FB_LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge CLK_50MHz) begin
    if (RESET || accept || (state == ST_IDLE) || (state == ST_FILLING)) begin
      to_cnt <= '0;
    end else if (!timeout_hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state <= ST_IDLE;
      x_reg <= '0;
      y_reg <= '0;
      cnt   <= '0;
      WE    <= 1'b0;
      WA    <= '0;
      WD    <= '0;
      DONE  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      WE   <= 1'b0;
      DONE <= 1'b0;
      ERR  <= 1'b0;
      if (timeout_hit && !accept) begin
        state <= ST_IDLE;
        ERR   <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (accept) begin
              case (RX_DATA)
                OP_PIXEL: state <= ST_PIX_X;
                OP_FILL:  state <= ST_FILL_C;
                OP_FRAME: begin
                  state <= ST_FRAME_DATA;
                  cnt   <= '0;
                end
                default:  ERR <= 1'b1;
              endcase
            end
          end
          ST_PIX_X: begin
            if (accept) begin
              x_reg <= RX_DATA;
              state <= ST_PIX_Y;
            end
          end
          ST_PIX_Y: begin
            if (accept) begin
              y_reg <= RX_DATA;
              state <= ST_PIX_C;
            end
          end
          ST_PIX_C: begin
            if (accept) begin
              state <= ST_IDLE;
              if (pix_ok) begin
                WE   <= 1'b1;
                WA   <= pix_addr;
                WD   <= RX_DATA;
                DONE <= 1'b1;
              end else begin
                ERR <= 1'b1;
              end
            end
          end
          // The first fill write goes out with the colour byte; the counter
          // then covers the rest, and FILLING lingers one more cycle so
          // RX_READY stays low through the final write.
          ST_FILL_C: begin
            if (accept) begin
              WE    <= 1'b1;
              WA    <= '0;
              WD    <= RX_DATA;
              cnt   <= FB_AW'(1);
              state <= ST_FILLING;
            end
          end
          ST_FILLING: begin
            if (cnt == FB_END) begin
              state <= ST_IDLE;
            end else begin
              WE   <= 1'b1;
              WA   <= cnt;
              DONE <= (cnt == FB_LAST);
              cnt  <= cnt + FB_AW'(1);
            end
          end
          ST_FRAME_DATA: begin
            if (accept) begin
              WE <= 1'b1;
              WA <= cnt;
              WD <= RX_DATA;
              if (cnt == FB_LAST) begin
                DONE  <= 1'b1;
                state <= ST_IDLE;
              end else begin
                cnt <= cnt + FB_AW'(1);
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_fb_loader_80x60.sv
// Randomized self-checking bench for uart_fb_loader_80x60: a command-level
// model predicts every output each cycle, backed by literal spot checks.
module tb_uart_fb_loader_80x60;

  logic        CLK_50MHz = 1'b0;
  logic        RESET;
  logic [7:0]  RX_DATA;
  logic        RX_VALID;
  logic        RX_READY;
  logic        WE;
  logic [12:0] WA;
  logic [7:0]  WD;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #10 CLK_50MHz = ~CLK_50MHz;

  uart_fb_loader_80x60 dut (
    .CLK_50MHz (CLK_50MHz),
    .RESET     (RESET),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .RX_READY  (RX_READY),
    .WE        (WE),
    .WA        (WA),
    .WD        (WD),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .ERR       (ERR)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic step();
    @(posedge CLK_50MHz);
    #1;
  endtask

  // Presents one byte and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [7:0] b);
    bit ok = 1'b0;
    RX_DATA  = b;
    RX_VALID = 1'b1;
    for (int i = 0; i < 6000 && !ok; i++) begin
      @(negedge CLK_50MHz);
      if (RX_READY) ok = 1'b1;
      step();
    end
    RX_VALID = 1'b0;
    if (!ok) checkOutput("rx_accept", int'(ok), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Reference model: expected outputs for the next cycle, derived from the
  // command bytes seen so far.
  logic        m_we, m_done, m_err, m_busy, m_rdy;
  logic [12:0] m_wa;
  logic [7:0]  m_wd;
  bit          exp_valid   = 1'b0;
  bit          fill_active = 1'b0;
  bit          frame_on    = 1'b0;
  int          fill_idx, frame_idx;
  logic [7:0]  fill_col;
  logic [7:0]  cmd_q[$];

  function automatic int pack_vec(logic r, logic bz, logic d, logic e, logic w,
                                  logic [12:0] a, logic [7:0] dat);
    return int'({6'd0, r, bz, d, e, w, a, dat});
  endfunction

  initial begin
    int x, y;
    logic [7:0] b;
    forever begin
      @(negedge CLK_50MHz);
      if (exp_valid)
        checkOutput("cycle {rdy,busy,done,err,we,wa,wd}",
                    pack_vec(RX_READY, BUSY, DONE, ERR, WE, WA, WD),
                    pack_vec(m_rdy, m_busy, m_done, m_err, m_we, m_wa, m_wd));
      if (RESET) begin
        m_we = 0; m_done = 0; m_err = 0; m_busy = 0; m_rdy = 1;
        m_wa = '0; m_wd = '0;
        cmd_q.delete();
        fill_active = 0;
        frame_on    = 0;
        exp_valid   = 1;
      end else if (exp_valid) begin
        logic accepted;
        accepted = RX_VALID && m_rdy;
        m_we = 0; m_done = 0; m_err = 0;
        if (accepted) begin
          b = RX_DATA;
          if (frame_on) begin
            m_we = 1; m_wa = 13'(frame_idx); m_wd = b;
            if (frame_idx == 4799) begin
              m_done   = 1;
              frame_on = 0;
            end
            frame_idx++;
          end else begin
            cmd_q.push_back(b);
            case (cmd_q[0])
              8'h01: if (cmd_q.size() == 4) begin
                x = int'(cmd_q[1]);
                y = int'(cmd_q[2]);
                if (x < 80 && y < 60) begin
                  m_we = 1; m_wa = 13'(y * 80 + x); m_wd = cmd_q[3]; m_done = 1;
                end else begin
                  m_err = 1;
                end
                cmd_q.delete();
              end
              8'h02: if (cmd_q.size() == 2) begin
                fill_active = 1;
                fill_idx    = 0;
                fill_col    = cmd_q[1];
                cmd_q.delete();
              end
              8'h03: begin
                frame_on  = 1;
                frame_idx = 0;
                cmd_q.delete();
              end
              default: begin
                m_err = 1;
                cmd_q.delete();
              end
            endcase
          end
        end
        if (fill_active) begin
          m_we = 1; m_wa = 13'(fill_idx); m_wd = fill_col;
          m_done = (fill_idx == 4799);
          fill_idx++;
          if (fill_idx == 4800) fill_active = 0;
          m_rdy  = 0;
          m_busy = 1;
        end else begin
          m_rdy  = 1;
          m_busy = (cmd_q.size() != 0) || frame_on;
        end
      end
    end
  end

  task automatic send_pixel(input logic [7:0] op, input logic [7:0] x,
                            input logic [7:0] y, input logic [7:0] c, input int max_gap);
    applyStimulus(op);
    if (op != 8'h01) return;
    idle($urandom_range(0, max_gap));
    applyStimulus(x);
    idle($urandom_range(0, max_gap));
    applyStimulus(y);
    idle($urandom_range(0, max_gap));
    applyStimulus(c);
  endtask

  initial begin
    int n;
    int last_wa;
    RESET    = 1'b1;
    RX_VALID = 1'b0;
    RX_DATA  = 8'h00;
    idle(3);
    checkOutput("reset_we", int'(WE), 0);
    checkOutput("reset_wa", int'(WA), 0);
    checkOutput("reset_busy", int'(BUSY), 0);
    checkOutput("reset_rx_ready", int'(RX_READY), 1);
    RESET = 1'b0;
    step();

    send_pixel(8'h01, 8'h05, 8'h03, 8'hE5, 0);
    checkOutput("pix_we", int'(WE), 1);
    checkOutput("pix_wa", int'(WA), 245);
    checkOutput("pix_wd", int'(WD), 8'hE5);
    checkOutput("pix_done", int'(DONE), 1);
    step();
    checkOutput("pix_busy_after", int'(BUSY), 0);

    send_pixel(8'h01, 8'd80, 8'd0, 8'hFF, 0);
    checkOutput("oor_we", int'(WE), 0);
    checkOutput("oor_err", int'(ERR), 1);
    step();

    for (int i = 0; i < 60; i++) begin
      logic [7:0] op, x, y;
      op = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255)) : 8'h01;
      x  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 90));
      y  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 66));
      send_pixel(op, x, y, 8'($urandom), 2);
      idle($urandom_range(0, 2));
    end

    send_pixel(8'h01, 8'd79, 8'd59, 8'h5A, 0);
    checkOutput("corner_wa", int'(WA), 4799);
    checkOutput("corner_we", int'(WE), 1);
    step();

    applyStimulus(8'h02);
    applyStimulus(8'h1C);
    n = 0;
    last_wa = -1;
    while (WE && n < 5000) begin
      if (DONE) last_wa = int'(WA);
      n++;
      step();
    end
    checkOutput("fill_len", n, 4800);
    checkOutput("fill_done_wa", last_wa, 4799);
    checkOutput("fill_ready_after", int'(RX_READY), 1);

    applyStimulus(8'h03);
    for (int k = 0; k < 4800; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      applyStimulus(8'($urandom));
      if (k == 0) checkOutput("frame_first_wa", int'(WA), 0);
    end
    checkOutput("frame_done", int'(DONE), 1);
    checkOutput("frame_last_wa", int'(WA), 4799);
    applyStimulus(8'h07);
    checkOutput("bad_op_err", int'(ERR), 1);
    step();

    applyStimulus(8'h02);
    applyStimulus(8'hAA);
    for (int i = 0; i < 6000 && WA != 13'd1000; i++) step();
    checkOutput("fill_reach_1000", int'(WA), 1000);
    RESET = 1'b1;
    step();
    checkOutput("midfill_rst_we", int'(WE), 0);
    checkOutput("midfill_rst_busy", int'(BUSY), 0);
    checkOutput("midfill_rst_ready", int'(RX_READY), 1);
    RESET = 1'b0;
    step();
    send_pixel(8'h01, 8'd10, 8'd2, 8'h77, 1);
    checkOutput("post_rst_pix_wa", int'(WA), 170);
    checkOutput("post_rst_pix_wd", int'(WD), 8'h77);
    idle(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_fb_loader_80x60.md
Name: uart_fb_loader_80x60

Overview:
Upstream stage feeding the 80x60 SPI framebuffer display driver's write port (WE/WA/WD).
- Consumes a byte stream from the UART receiver through a valid/ready handshake.
- Decodes a small command protocol: set pixel, fill screen, stream full frame.
- Emits single-cycle framebuffer writes, one pixel (RGB332 byte) per write.

Parameters:
H_PIX, 80, horizontal pixels; x range 0..H_PIX-1.
V_PIX, 60, vertical pixels; y range 0..V_PIX-1.
TIMEOUT_CYCLES, 5000000, inter-byte timeout in clocks (100 ms at 50 MHz); used only with the optional feature.

Ports:
CLK_50MHz  in  1  system clock; all logic on rising edge.
RESET  in  1  synchronous, active-high reset.
RX_DATA  in  8  received UART byte.
RX_VALID  in  1  RX_DATA valid.
RX_READY  out  1  loader can accept a byte; transfer occurs when RX_VALID && RX_READY.
WE  out  1  framebuffer write enable, one cycle per pixel.
WA  out  13  framebuffer address, y*H_PIX+x, range 0..4799.
WD  out  8  pixel colour written.
BUSY  out  1  high while a command is partially received or a fill is in progress.
DONE  out  1  one-cycle pulse when a command completes.
ERR  out  1  one-cycle pulse on a rejected command.

Behaviour:
- Reset (synchronous): state IDLE; WE=0, WA=0, WD=0, DONE=0, ERR=0, BUSY=0, RX_READY=1. Any partial command is discarded. Reset wins over all simultaneous events.
- Outputs are registered. WE/WA/WD change in the cycle after the byte that causes them is accepted, so write latency is 1 clock.
- Opcodes, accepted in IDLE:
  - 0x01 PIXEL: followed by x, y, colour.
  - 0x02 FILL: followed by colour.
  - 0x03 FRAME: followed by 4800 colour bytes.
  - Any other opcode: consumed, ERR pulses next cycle, state stays IDLE.
- States: IDLE -> PIX_X -> PIX_Y -> PIX_C -> IDLE; IDLE -> FILL_C -> FILLING -> IDLE; IDLE -> FRAME_DATA -> IDLE.
- PIXEL:
  - On the colour byte, if x<H_PIX and y<V_PIX: WE=1 for one cycle, WA=y*80+x (computed as (y<<6)+(y<<4)+x, 13 bits), WD=colour. DONE pulses in the same cycle as WE.
  - If out of range: no write, ERR pulses instead.
- FILL:
  - After the colour byte is accepted, RX_READY=0 and WE=1 for exactly 4800 consecutive cycles, WA=0..4799, WD=colour.
  - DONE pulses with the write to WA=4799. RX_READY returns to 1 on the following cycle.
- FRAME:
  - Write counter starts at 0. Each accepted byte produces WE=1 next cycle at the current counter, then the counter increments. RX_READY stays 1.
  - Gaps in RX_VALID simply stall; WE stays 0 while stalled.
  - DONE pulses with the write to WA=4799; state returns to IDLE; the counter never exceeds 4799.
- WE=0 in every cycle not listed above. WA/WD hold their last values when WE=0.
- BUSY=1 in every state except IDLE.
- DONE and ERR are never high in the same cycle.

Optional Feature:
- Macro: UART_FB_LOADER_TIMEOUT_EN.
- Defined: a counter clears on every accepted byte and increments while BUSY is high and the state is not FILLING. When it reaches TIMEOUT_CYCLES, the loader returns to IDLE, pulses ERR, and discards the partial command. Writes already issued are not undone.
- Undefined: no counter is present; a partial command waits indefinitely.

Decomposition:
- Package uart_fb_loader_pkg:
  - Opcode constants OP_PIXEL, OP_FILL, OP_FRAME.
  - FB_DEPTH=4800, FB_AW=13.
  - State enum typedef.
- Sub-module fb_xy_to_addr: combinational. Inputs x[6:0], y[5:0]; outputs addr[12:0] and in_range.

Test Plan:
- Reset, then PIXEL 0x01,0x05,0x03,0xE5 -> one WE cycle with WA=245, WD=0xE5; DONE in the same cycle; BUSY low afterwards.
- PIXEL 0x01,80,0,0xFF (x out of range) -> no WE; ERR pulses once; next command is accepted normally.
- FILL 0x02,0x1C -> 4800 consecutive WE cycles, WA 0..4799, WD=0x1C; RX_READY low throughout; DONE with WA=4799.
- FRAME 0x03 then 4800 bytes with random RX_VALID gaps -> the nth byte is written at WA=n-1; DONE at 4799; a following opcode 0x07 gives ERR.
- RESET asserted mid-FILL at WA=1000 -> WE=0 and state IDLE at the next edge; a new PIXEL command then succeeds.
- With UART_FB_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send 0x01,0x02 then idle 100 cycles -> ERR, BUSY low, no WE.
